// File: rtl/me_fetch_ctrl.sv
// Motion-estimation fetch controller: loads the current macroblock, then walks the search window in snake order.
// Optional early termination on a zero SAD is built when ME_FETCH_EARLY_TERM_EN is defined.
module me_fetch_ctrl #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_LAT    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         cur_rd_en,
    output logic [3:0]                   cur_rd_row,
    input  logic [8*MACRO_DIM-1:0]       cur_rd_data,
    output logic                         win_rd_en,
    output logic                         win_rd_vert,
    output logic [5:0]                   win_rd_row,
    output logic [5:0]                   win_rd_col,
    input  logic [8*(MACRO_DIM+1)-1:0]   win_rd_data,
    output logic [8*MACRO_DIM-1:0]       pixel_cpr_out,
    output logic [8*(MACRO_DIM+1)-1:0]   pixel_spr_out,
    output logic                         en_cpr,
    output logic                         en_spr,
    output logic [1:0]                   sel,
    output logic                         valid,
    output logic [5:0]                   addr,
    output logic [5:0]                   amt
`ifdef ME_FETCH_EARLY_TERM_EN
    ,
    input  logic [15:0]                  min_sad_in
`endif
);

    localparam int P = SEARCH_DIM - MACRO_DIM + 1;
    localparam logic [5:0] L_MD        = 6'(MACRO_DIM);
    localparam logic [5:0] L_MD_LAST   = 6'(MACRO_DIM - 1);
    localparam logic [5:0] L_P_LAST    = 6'(P - 1);
    localparam logic [5:0] L_DRAIN_END = 6'(SAD_LAT);

    typedef enum logic [2:0] {IDLE, LOAD_CUR, FILL, SCAN, HMOVE, DRAIN, DONE} state_t;

    state_t      r_state, w_stateNext;
    logic [5:0]  r_cnt, w_cntNext;
    logic [5:0]  r_col, w_colNext;
    logic [5:0]  r_row, w_rowNext;
    logic        w_curRdEn, w_winRdEn, w_winRdVert, w_posDone, w_earlyStop, w_scanEnd;
    logic [3:0]  w_curRdRow;
    logic [5:0]  w_winRdRow, w_winRdCol, w_posAddr, w_posAmt;
    logic [1:0]  w_selRd;
    logic        r_enCpr, r_enSpr;
    logic [1:0]  r_sel;
    logic        r_vPipe    [0:SAD_LAT];
    logic [5:0]  r_addrPipe [0:SAD_LAT];
    logic [5:0]  r_amtPipe  [0:SAD_LAT];

`ifdef ME_FETCH_EARLY_TERM_EN
    logic r_validD;
    always_ff @(posedge clk) begin
        if (!rst_n) r_validD <= 1'b0;
        else        r_validD <= valid;
    end
    assign w_earlyStop = r_validD && (min_sad_in == 16'd0);
`else
    assign w_earlyStop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_col   <= w_colNext;
            r_row   <= w_rowNext;
        end
    end

    // The last row of a snake leg is reached on the read that lands y on P-1 (even) or 0 (odd).
    assign w_scanEnd = r_col[0] ? (r_row == 6'd1) : (r_row == L_P_LAST - 6'd1);

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_colNext   = r_col;
        w_rowNext   = r_row;
        w_curRdEn   = 1'b0;
        w_curRdRow  = '0;
        w_winRdEn   = 1'b0;
        w_winRdVert = 1'b0;
        w_winRdRow  = '0;
        w_winRdCol  = '0;
        w_selRd     = 2'b00;
        w_posDone   = 1'b0;
        w_posAddr   = '0;
        w_posAmt    = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = LOAD_CUR;
                    w_cntNext   = '0;
                    w_colNext   = '0;
                    w_rowNext   = '0;
                end
            end
            LOAD_CUR: begin
                w_curRdEn  = 1'b1;
                w_curRdRow = r_cnt[3:0];
                if (r_cnt == L_MD_LAST) begin
                    w_cntNext   = '0;
                    w_stateNext = FILL;
                end else begin
                    w_cntNext = r_cnt + 6'd1;
                end
            end
            FILL: begin
                if (w_earlyStop) begin
                    w_stateNext = DRAIN;
                end else begin
                    w_winRdEn  = 1'b1;
                    w_winRdRow = r_cnt;
                    if (r_cnt == L_MD_LAST) begin
                        w_posDone   = 1'b1;
                        w_cntNext   = '0;
                        w_stateNext = (P == 1) ? DRAIN : SCAN;
                    end else begin
                        w_cntNext = r_cnt + 6'd1;
                    end
                end
            end
            SCAN: begin
                if (w_earlyStop) begin
                    w_stateNext = DRAIN;
                end else begin
                    w_winRdEn  = 1'b1;
                    w_winRdCol = r_col;
                    if (!r_col[0]) begin
                        w_winRdRow = r_row + L_MD;
                        w_selRd    = 2'b00;
                        w_rowNext  = r_row + 6'd1;
                    end else begin
                        w_winRdRow = r_row - 6'd1;
                        w_selRd    = 2'b01;
                        w_rowNext  = r_row - 6'd1;
                    end
                    w_posDone = 1'b1;
                    w_posAmt  = r_col;
                    w_posAddr = w_rowNext;
                    if (w_scanEnd) w_stateNext = (r_col == L_P_LAST) ? DRAIN : HMOVE;
                end
            end
            HMOVE: begin
                if (w_earlyStop) begin
                    w_stateNext = DRAIN;
                end else begin
                    w_winRdEn   = 1'b1;
                    w_winRdVert = 1'b1;
                    w_winRdRow  = r_row;
                    w_winRdCol  = r_col + L_MD;
                    w_selRd     = 2'b10;
                    w_posDone   = 1'b1;
                    w_posAmt    = r_col + 6'd1;
                    w_posAddr   = r_row;
                    w_colNext   = r_col + 6'd1;
                    w_stateNext = SCAN;
                end
            end
            DRAIN: begin
                w_cntNext = r_cnt + 6'd1;
                if (r_cnt == L_DRAIN_END) w_stateNext = DONE;
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
        if (w_stateNext == DRAIN && r_state != DRAIN) w_cntNext = '0;
    end

    // Stage 0 lines up with en_spr; the SAD for that position emerges SAD_LAT stages later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_enCpr <= 1'b0;
            r_enSpr <= 1'b0;
            r_sel   <= 2'b00;
            for (int i = 0; i <= SAD_LAT; i++) begin
                r_vPipe[i]    <= 1'b0;
                r_addrPipe[i] <= '0;
                r_amtPipe[i]  <= '0;
            end
        end else begin
            r_enCpr       <= w_curRdEn;
            r_enSpr       <= w_winRdEn;
            r_sel         <= w_selRd;
            r_vPipe[0]    <= w_posDone;
            r_addrPipe[0] <= w_posAddr;
            r_amtPipe[0]  <= w_posAmt;
            for (int i = 1; i <= SAD_LAT; i++) begin
                r_vPipe[i]    <= r_vPipe[i-1];
                r_addrPipe[i] <= r_addrPipe[i-1];
                r_amtPipe[i]  <= r_amtPipe[i-1];
            end
        end
    end

    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign cur_rd_en     = w_curRdEn;
    assign cur_rd_row    = w_curRdRow;
    assign win_rd_en     = w_winRdEn;
    assign win_rd_vert   = w_winRdVert;
    assign win_rd_row    = w_winRdRow;
    assign win_rd_col    = w_winRdCol;
    assign pixel_cpr_out = cur_rd_data;
    assign pixel_spr_out = win_rd_data;
    assign en_cpr        = r_enCpr;
    assign en_spr        = r_enSpr;
    assign sel           = r_sel;
    assign valid         = r_vPipe[SAD_LAT];
    assign addr          = r_addrPipe[SAD_LAT];
    assign amt           = r_amtPipe[SAD_LAT];

endmodule

// File: tb/tb_me_fetch_ctrl.sv
// Scoreboard bench for me_fetch_ctrl at MACRO_DIM=4, SEARCH_DIM=8, SAD_LAT=2 (P=5).
// Define ME_FETCH_EARLY_TERM_EN to also exercise early termination.
module tb_me_fetch_ctrl;

    localparam int MD  = 4;
    localparam int SD  = 8;
    localparam int LAT = 2;
    localparam int P   = SD - MD + 1;

    typedef struct packed {
        logic       vert;
        logic [5:0] row;
        logic [5:0] col;
        logic [1:0] sel;
        logic       comp;
    } winExp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, cur_rd_en, win_rd_en, win_rd_vert, en_cpr, en_spr, valid;
    logic [3:0]        cur_rd_row;
    logic [5:0]        win_rd_row, win_rd_col, addr, amt;
    logic [1:0]        sel;
    logic [8*MD-1:0]   cur_rd_data = '0;
    logic [8*(MD+1)-1:0] win_rd_data = '0;
    logic [8*MD-1:0]   pixel_cpr_out;
    logic [8*(MD+1)-1:0] pixel_spr_out;
`ifdef ME_FETCH_EARLY_TERM_EN
    logic [15:0]       min_sad_in = 16'hFFFF;
`endif

    me_fetch_ctrl #(.MACRO_DIM(MD), .SEARCH_DIM(SD), .SAD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cur_rd_en(cur_rd_en), .cur_rd_row(cur_rd_row), .cur_rd_data(cur_rd_data),
        .win_rd_en(win_rd_en), .win_rd_vert(win_rd_vert), .win_rd_row(win_rd_row),
        .win_rd_col(win_rd_col), .win_rd_data(win_rd_data),
        .pixel_cpr_out(pixel_cpr_out), .pixel_spr_out(pixel_spr_out),
        .en_cpr(en_cpr), .en_spr(en_spr), .sel(sel), .valid(valid), .addr(addr), .amt(amt)
`ifdef ME_FETCH_EARLY_TERM_EN
        , .min_sad_in(min_sad_in)
`endif
    );

    always #5 clk = ~clk;

    int      checkCnt = 0;
    int      passCnt  = 0;
    int      cyc      = 0;
    int      validCnt = 0;
    int      doneCnt  = 0;
    bit      sbOn     = 1'b0;
    int      curQ[$];
    winExp_t winQ[$];
    logic [2:0] selQ[$];
    int      latQ[$];
    logic [11:0] posQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expected reads and SAD positions for one complete search.
    task automatic buildExpect();
        int y;
        for (int r = 0; r < MD; r++) curQ.push_back(r);
        for (int r = 0; r < MD; r++) winQ.push_back('{1'b0, 6'(r), 6'd0, 2'b00, (r == MD-1)});
        y = 0;
        for (int c = 0; c < P; c++) begin
            if (c > 0) winQ.push_back('{1'b1, 6'(y), 6'(c - 1 + MD), 2'b10, 1'b1});
            for (int k = 1; k < P; k++) begin
                if (c % 2 == 0) begin
                    winQ.push_back('{1'b0, 6'(y + MD), 6'(c), 2'b00, 1'b1});
                    y++;
                end else begin
                    winQ.push_back('{1'b0, 6'(y - 1), 6'(c), 2'b01, 1'b1});
                    y--;
                end
            end
        end
        for (int c = 0; c < P; c++)
            for (int k = 0; k < P; k++)
                posQ.push_back({6'(c), 6'((c % 2 == 0) ? k : P - 1 - k)});
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read, load or SAD strobe.
    always @(negedge clk) begin
        winExp_t w;
        logic [2:0] s;
        if (valid) validCnt++;
        if (done) doneCnt++;
        if (sbOn) begin
            if (cur_rd_en) begin
                if (curQ.size() == 0) checkOutput("curRdUnexpected", 1, 0);
                else checkOutput("curRdRow", cur_rd_row, curQ.pop_front());
            end
            if (en_spr) begin
                if (selQ.size() == 0) checkOutput("enSprUnexpected", 1, 0);
                else begin
                    s = selQ.pop_front();
                    checkOutput("selAtEnSpr", sel, s[2:1]);
                    if (s[0]) latQ.push_back(cyc + LAT);
                end
            end
            if (win_rd_en) begin
                if (winQ.size() == 0) checkOutput("winRdUnexpected", 1, 0);
                else begin
                    w = winQ.pop_front();
                    checkOutput("winRdVertRowCol", {win_rd_vert, win_rd_row, win_rd_col},
                                {w.vert, w.row, w.col});
                    selQ.push_back({w.sel, w.comp});
                end
            end
            if (valid) begin
                if (posQ.size() == 0 || latQ.size() == 0) checkOutput("validUnexpected", 1, 0);
                else begin
                    checkOutput("validAmtAddr", {amt, addr}, posQ.pop_front());
                    checkOutput("validLatency", cyc, latQ.pop_front());
                end
            end
        end
    end

    task automatic waitDone(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        int nValid;
        cur_rd_data = 32'hA1B2C3D4;
        win_rd_data = 40'h1122334455;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstRdEn", {cur_rd_en, win_rd_en}, 0);
        checkOutput("rstLoadEn", {en_cpr, en_spr}, 0);
        checkOutput("rstValid", valid, 0);
        checkOutput("rstSelAddrAmt", {sel, addr, amt}, 0);
        checkOutput("rstRowCol", {cur_rd_row, win_rd_vert, win_rd_row, win_rd_col}, 0);
        checkOutput("cprPassthrough", pixel_cpr_out, 64'hA1B2C3D4);
        checkOutput("sprPassthrough", pixel_spr_out, 64'h1122334455);
        rst_n = 1'b1;
        @(negedge clk);

        // Full search with a stray start pulse in the middle of the scan.
        $display("[TB] full search");
        buildExpect();
        validCnt = 0;
        doneCnt  = 0;
        sbOn     = 1'b1;
        applyStimulus();
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(200, seen);
        checkOutput("doneSeen", seen, 1);
        repeat (6) @(negedge clk);
        checkOutput("busyAfterDone", busy, 0);
        checkOutput("doneCount", doneCnt, 1);
        checkOutput("validCount", validCnt, P * P);
        checkOutput("queuesDrained", curQ.size() + winQ.size() + selQ.size() + posQ.size() + latQ.size(), 0);
        sbOn = 1'b0;
        curQ.delete(); winQ.delete(); selQ.delete(); posQ.delete(); latQ.delete();

        // Reset in the middle of a scan aborts the search.
        $display("[TB] reset mid-scan");
        applyStimulus();
        repeat (15) @(negedge clk);
        checkOutput("busyMidScan", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abortIdle", {busy, done, valid, en_spr, win_rd_en}, 0);
        validCnt = 0;
        doneCnt  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("abortNoValid", validCnt, 0);
        checkOutput("abortNoDone", doneCnt, 0);

`ifdef ME_FETCH_EARLY_TERM_EN
        $display("[TB] early termination");
        validCnt = 0;
        doneCnt  = 0;
        nValid   = 0;
        applyStimulus();
        for (int i = 0; i < 200 && nValid < 3; i++) begin
            @(negedge clk);
            if (valid) nValid++;
        end
        checkOutput("earlyThirdValid", nValid, 3);
        min_sad_in = 16'd0;
        waitDone(LAT + 3, seen);
        checkOutput("earlyDoneInTime", seen, 1);
        min_sad_in = 16'hFFFF;
        repeat (5) @(negedge clk);
        checkOutput("earlyFewerValid", (validCnt < P * P), 1);
        checkOutput("earlyBusyLow", busy, 0);
`else
        nValid = 0;
        seen   = 1'b0;
`endif

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/me_fetch_ctrl.md
ME_FETCH_CTRL -- requirements
Module: me_fetch_ctrl

Interface
REQ-001 SHALL have parameter MACRO_DIM, default 16, macroblock edge in pixels.
REQ-002 SHALL have parameter SEARCH_DIM, default 48, search-window edge in pixels; P = SEARCH_DIM-MACRO_DIM+1 positions per axis.
REQ-003 SHALL have parameter SAD_LAT, default 2, cycles from last spr load of a position to its SAD at the comparator.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  begin one macroblock search; sampled only in IDLE.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse at search end.
REQ-009 cur_rd_en / cur_rd_row  out  1 / 4  current-MB row read request.
REQ-010 cur_rd_data  in  8*MACRO_DIM  row data, valid one cycle after cur_rd_en.
REQ-011 win_rd_en / win_rd_vert / win_rd_row / win_rd_col  out  1 / 1 / 6 / 6  window read; vert=0: 17 pixels of row at cols col..col+16; vert=1: 16 pixels of column col, rows row..row+15, lane 16 zero.
REQ-012 win_rd_data  in  8*(MACRO_DIM+1)  window data, valid one cycle after win_rd_en.
REQ-013 pixel_cpr_out / pixel_spr_out  out  8*MACRO_DIM / 8*(MACRO_DIM+1)  cur_rd_data / win_rd_data passed through combinationally.
REQ-014 en_cpr / en_spr  out  1 / 1  load strobes; each is its rd_en delayed one cycle.
REQ-015 sel  out  2  00 down shift, 01 up shift, 10 left shift (column move); rd-time value delayed one cycle, aligned with en_spr.
REQ-016 valid / addr / amt  out  1 / 6 / 6  SAD-valid strobe, vertical (addr) and horizontal (amt) position of that SAD.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_CUR, FILL, SCAN, HMOVE, DRAIN, DONE.
REQ-018 IDLE->LOAD_CUR on start; LOAD_CUR SHALL issue MACRO_DIM cur reads, rows 0..MACRO_DIM-1, one per cycle.
REQ-019 FILL SHALL issue MACRO_DIM row reads (vert=0, col 0, rows 0..MACRO_DIM-1, sel 00), back-to-back after LOAD_CUR.
REQ-020 SCAN on even column c SHALL read rows y+MACRO_DIM with sel 00 until y=P-1; on odd column read row y-1 with sel 01 until y=0; one read per cycle.
REQ-021 HMOVE SHALL issue one vert=1 read at col c+MACRO_DIM, row y, sel 10, then return to SCAN with c+1; after column P-1 go to DRAIN.
REQ-022 Position (c,y) is complete on the edge its last en_spr is sampled; valid SHALL pulse exactly SAD_LAT cycles later with amt=c, addr=y.
REQ-023 Exactly P*P valid pulses per search, snake order, no gaps counted beyond HMOVE cycles.
REQ-024 DRAIN SHALL last SAD_LAT+1 cycles; DONE lasts one cycle, asserts done, then IDLE.
REQ-025 start outside IDLE SHALL be ignored; start in DONE ignored.
REQ-026 Row/column counters SHALL never exceed P-1; no read outside the window.

Reset
REQ-027 rst_n low SHALL force IDLE next edge; busy, done, all rd_en, en_cpr, en_spr, valid = 0; sel, addr, amt, row/col outputs = 0.
REQ-028 Reset mid-search SHALL abort; no valid or done after reset edge; pending pipeline strobes cleared.

Configuration
REQ-029 Macro ME_FETCH_EARLY_TERM_EN: when defined, input min_sad_in [15:0] exists; min_sad_in==0 sampled the cycle after any valid SHALL stop issuing reads and go to DRAIN.
REQ-030 Without ME_FETCH_EARLY_TERM_EN the port is absent and every search issues all P*P positions.

Verification (MACRO_DIM=4, SEARCH_DIM=8, P=5, SAD_LAT=2)
REQ-031 Hold rst_n=0 3 cycles -> all outputs 0, busy=0.
REQ-032 start pulse -> cur_rd_row 0,1,2,3; win rows 0..3 col 0; then rows 4..7; then vert read col 4 row 4.
REQ-033 Full search -> 25 valid pulses, (amt,addr) = (0,0)..(0,4),(1,4)..(1,0),(2,0)..,(4,4); single done pulse; busy low after.
REQ-034 start asserted mid-scan -> ignored; rst_n=0 mid-scan -> IDLE next cycle, no further valid/done.
REQ-035 With ME_FETCH_EARLY_TERM_EN, min_sad_in=0 after third valid -> reads stop, done within SAD_LAT+3 cycles, fewer than 25 valid; without macro 25 valid.
